// File: rtl/cis_pkg.sv
// Shared types and default timing constants for the image-sensor capture sequencer.
package cis_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ
  } state_t;

  localparam int ERASE_CYCLES   = 5;
  localparam int CONVERT_CYCLES = 255;
  localparam int EXP_DEFAULT    = 255;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/capture_sequencer.sv
// Sequences erase/expose/convert/readout phases of a pixel array and hands
// pixel indices to a downstream consumer with valid/ready flow control.
module capture_sequencer #(
  parameter int PIXEL_COUNT    = 4,
  parameter int ERASE_CYCLES   = cis_pkg::ERASE_CYCLES,
  parameter int CONVERT_CYCLES = cis_pkg::CONVERT_CYCLES,
  parameter int EXP_W          = 16,
  parameter int EXP_DEFAULT    = cis_pkg::EXP_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           continuous,
  input  logic                           abort,
  input  logic                           cfg_we,
  input  logic [EXP_W-1:0]               cfg_exposure,
  output logic                           erase,
  output logic                           expose,
  output logic                           convert,
  output logic                           read,
  output logic [$clog2(PIXEL_COUNT)-1:0] pixel_select,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic                           busy,
  output logic                           frame_done,
  output logic [15:0]                    frame_count
);
  import cis_pkg::*;

  localparam int PIX_W = $clog2(PIXEL_COUNT);
  localparam int CNT_W = max3(EXP_W, 8, PIX_W);

  state_t             state_q, state_d;
  logic [EXP_W-1:0]   exp_reg_q, exp_reg_d;
  logic [EXP_W-1:0]   exp_shadow_q, exp_shadow_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic               frame_done_q, frame_done_d;
  logic [15:0]        frame_count_q, frame_count_d;

  logic               timer_load;
  logic [CNT_W-1:0]   timer_value;
  logic               timer_tc;
  logic [CNT_W-1:0]   expose_load;

  phase_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .tc         (timer_tc)
  );

  // A zero exposure is stretched to one cycle.
  always_comb begin
    if (exp_shadow_q == '0) begin
      expose_load = '0;
    end else begin
      expose_load = CNT_W'(exp_shadow_q) - CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    exp_reg_d     = cfg_we ? cfg_exposure : exp_reg_q;
    exp_shadow_d  = exp_shadow_q;
    pix_d         = pix_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    timer_load    = 1'b0;
    timer_value   = '0;

    if (state_q == S_IDLE) begin
      if (start && !abort) begin
        state_d      = S_ERASE;
        exp_shadow_d = exp_reg_q;
        timer_load   = 1'b1;
        timer_value  = CNT_W'(ERASE_CYCLES - 1);
      end
    end else if (abort) begin
      state_d = S_IDLE;
      pix_d   = '0;
    end else begin
      case (state_q)
        S_ERASE: begin
          if (timer_tc) begin
            state_d     = S_EXPOSE;
            timer_load  = 1'b1;
            timer_value = expose_load;
          end
        end
        S_EXPOSE: begin
          if (timer_tc) begin
            state_d     = S_CONVERT;
            timer_load  = 1'b1;
            timer_value = CNT_W'(CONVERT_CYCLES - 1);
          end
        end
        S_CONVERT: begin
          if (timer_tc) begin
            state_d = S_READ;
            pix_d   = '0;
          end
        end
        S_READ: begin
          if (pix_ready) begin
            if (pix_q == PIX_W'(PIXEL_COUNT - 1)) begin
              pix_d         = '0;
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
              if (continuous) begin
                state_d      = S_ERASE;
                exp_shadow_d = exp_reg_q;
                timer_load   = 1'b1;
                timer_value  = CNT_W'(ERASE_CYCLES - 1);
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              pix_d = pix_q + PIX_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      exp_reg_q     <= EXP_W'(EXP_DEFAULT);
      exp_shadow_q  <= EXP_W'(EXP_DEFAULT);
      pix_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      exp_reg_q     <= exp_reg_d;
      exp_shadow_q  <= exp_shadow_d;
      pix_q         <= pix_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign erase        = (state_q == S_ERASE);
  assign expose       = (state_q == S_EXPOSE);
  assign convert      = (state_q == S_CONVERT);
  assign read         = (state_q == S_READ);
  assign pix_valid    = read;
  assign pixel_select = pix_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench: stimulus queues expected phase lengths, pixel handshakes and
// frame completions; a negedge monitor pops and compares as the DUT produces them.
module tb_capture_sequencer;

  localparam int K_ERASE = 0, K_EXPOSE = 1, K_CONVERT = 2, K_PIX = 3, K_DONE = 4;

  logic        clk = 1'b0;
  logic        reset, start, continuous, abort, cfg_we, pix_ready;
  logic [15:0] cfg_exposure;
  logic        erase, expose, convert, read, pix_valid, busy, frame_done;
  logic [1:0]  pixel_select;
  logic [15:0] frame_count;

  typedef struct { int kind; int val; } exp_t;
  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int er_len = 0, ex_len = 0, cv_len = 0;

  always #5 clk = ~clk;

  capture_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .abort        (abort),
    .cfg_we       (cfg_we),
    .cfg_exposure (cfg_exposure),
    .erase        (erase),
    .expose       (expose),
    .convert      (convert),
    .read         (read),
    .pixel_select (pixel_select),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_count  (frame_count)
  );

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  task automatic sb_push(input int kind, input int val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    sbq.push_back(e);
  endtask

  task automatic push_frame(input int exp_len, input int count);
    sb_push(K_ERASE, 5);
    sb_push(K_EXPOSE, exp_len);
    sb_push(K_CONVERT, 255);
    for (int i = 0; i < 4; i++) sb_push(K_PIX, i);
    sb_push(K_DONE, count);
  endtask

  task automatic sb_pop(input int kind, input int val);
    exp_t e;
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_unexpected: got kind %0d value %0d, expected nothing", kind, val);
    end else begin
      e = sbq.pop_front();
      check("sb_kind", kind, e.kind);
      check("sb_value", val, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (erase) er_len++;
      else if (er_len > 0) begin sb_pop(K_ERASE, er_len); er_len = 0; end
      if (expose) ex_len++;
      else if (ex_len > 0) begin sb_pop(K_EXPOSE, ex_len); ex_len = 0; end
      if (convert) cv_len++;
      else if (cv_len > 0) begin sb_pop(K_CONVERT, cv_len); cv_len = 0; end
      if (pix_valid && pix_ready) sb_pop(K_PIX, int'(pixel_select));
      if (frame_done) sb_pop(K_DONE, int'(frame_count));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int what);
    case (what)
      0: return !busy;
      1: return expose;
      2: return convert;
      3: return read && pixel_select == 2'd2;
      4: return read && pixel_select == 2'd3;
      default: return frame_done;
    endcase
  endfunction

  task automatic wait_until(input int what, input string name);
    int n = 0;
    while (!cond(what) && n < 3000) begin
      tick(1);
      n++;
    end
    check(name, int'(cond(what)), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic write_exp(input int v);
    cfg_we = 1'b1;
    cfg_exposure = 16'(v);
    tick(1);
    cfg_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    cfg_we = 1'b0; cfg_exposure = '0; pix_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset_busy", int'(busy), 0);
    check("reset_strobes", int'({erase, expose, convert, read, pix_valid}), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_pixel_select", int'(pixel_select), 0);
    check("reset_frame_count", int'(frame_count), 0);

    // Basic frame with default timing.
    push_frame(255, 1);
    pulse_start();
    check("erase_after_start", int'(erase), 1);
    wait_until(0, "frame1_idle");
    check("frame1_count", int'(frame_count), 1);

    // Mid-frame exposure write only applies to the following frame.
    push_frame(255, 2);
    push_frame(10, 3);
    pulse_start();
    wait_until(1, "frame2_expose");
    tick(20);
    write_exp(10);
    wait_until(0, "frame2_idle");
    pulse_start();
    wait_until(0, "frame3_idle");
    write_exp(0);
    push_frame(1, 4);
    pulse_start();
    wait_until(0, "frame4_idle");

    // Backpressure holding pixel 2 for three cycles.
    push_frame(1, 5);
    pulse_start();
    wait_until(3, "bp_at_pix2");
    pix_ready = 1'b0;
    repeat (3) begin
      check("bp_pixel_hold", int'(pixel_select), 2);
      check("bp_valid", int'(pix_valid), 1);
      check("bp_no_done", int'(frame_done), 0);
      tick(1);
    end
    pix_ready = 1'b1;
    wait_until(0, "frame5_idle");
    check("frame5_count", int'(frame_count), 5);

    // Continuous mode: three back-to-back frames, stray starts ignored.
    continuous = 1'b1;
    push_frame(1, 6);
    push_frame(1, 7);
    push_frame(1, 8);
    pulse_start();
    tick(20);
    pulse_start();
    wait_until(5, "cont_done1");
    check("cont_no_idle_gap1", int'(erase), 1);
    tick(1);
    wait_until(5, "cont_done2");
    check("cont_no_idle_gap2", int'(erase), 1);
    continuous = 1'b0;
    pulse_start();
    wait_until(0, "cont_idle");
    check("cont_count", int'(frame_count), 8);
    tick(5);
    check("cont_stays_idle", int'(busy), 0);

    // Abort during CONVERT after four convert cycles.
    sb_push(K_ERASE, 5);
    sb_push(K_EXPOSE, 1);
    sb_push(K_CONVERT, 4);
    pulse_start();
    wait_until(2, "abort_cv_reach");
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_cv_idle", int'(busy), 0);
    tick(3);
    check("abort_cv_count", int'(frame_count), 8);

    // Abort wins over the final handshake.
    sb_push(K_ERASE, 5);
    sb_push(K_EXPOSE, 1);
    sb_push(K_CONVERT, 255);
    for (int i = 0; i < 4; i++) sb_push(K_PIX, i);
    pulse_start();
    wait_until(4, "abort_rd_reach");
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_rd_idle", int'(busy), 0);
    check("abort_rd_no_done", int'(frame_done), 0);
    tick(3);
    check("abort_rd_count", int'(frame_count), 8);

    // Abort beats a simultaneous start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    check("abort_vs_start", int'(busy), 0);

    // Asynchronous reset mid-READ, then a default frame.
    write_exp(7);
    sb_push(K_ERASE, 5);
    sb_push(K_EXPOSE, 7);
    sb_push(K_CONVERT, 255);
    sb_push(K_PIX, 0);
    sb_push(K_PIX, 1);
    pulse_start();
    wait_until(3, "rst_reach_read");
    reset = 1'b1;
    #1;
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_outs", int'({erase, expose, convert, read, pix_valid, frame_done}), 0);
    check("rst_async_pix", int'(pixel_select), 0);
    check("rst_async_count", int'(frame_count), 0);
    tick(2);
    reset = 1'b0;
    tick(5);
    check("rst_no_resume", int'(busy), 0);
    push_frame(255, 1);
    pulse_start();
    wait_until(0, "post_rst_idle");
    check("post_rst_count", int'(frame_count), 1);

    tick(2);
    check("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
